// File: rtl/imem_ldr_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   ldr_state_e : loader FSM states
//   WORD_BYTES  : byte stride between consecutive instruction words
//   BOOT_BASE   : default byte address of the first loaded word
package imem_ldr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    ERR
  } ldr_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] BOOT_BASE  = 32'h0000_0000;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot/reload sequencer for the single-cycle MIPS core's instruction memory.
// Streams 32-bit words from a valid/ready source into consecutive word
// addresses of the instruction RAM, holding the core in reset until the whole
// image has been written.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start_i, len_i    begin a load session of len_i words (IDLE/RUN/ERR only)
//   abort_i           cancel a load in progress (LOAD/DRAIN only)
//   data_valid_i      data_i carries a word; accepted while data_ready_o is high
//   data_ready_o      combinational: high exactly while in LOAD
//   wr_en_imem_o      one-cycle write pulse per accepted word
//   addr_imem_o       byte address of the word being written
//   wr_instr_imem_o   instruction word being written
//   cpu_reset_o       core reset, low only in RUN
//   busy_o/done_o/err_o  status: LOAD or DRAIN / RUN / ERR
//   checksum_o        wrapping 32-bit sum of words accepted this session
module imem_boot_loader
  import imem_ldr_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = BOOT_BASE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [ADDR_W:0] len_i,
  input  logic            abort_i,
  input  logic            data_valid_i,
  input  logic [31:0]     data_i,
  output logic            data_ready_o,
  output logic            wr_en_imem_o,
  output logic [31:0]     addr_imem_o,
  output logic [31:0]     wr_instr_imem_o,
  output logic            cpu_reset_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [31:0]     checksum_o
);

  // Largest legal length is the full RAM depth.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_e      state_q;
  ldr_state_e      state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] count_q;
  logic            accept;
  logic            last_accept;
  logic            start_ok;
  logic            start_load;

  // Handshake, length validation and next-state decode. A word presented
  // alongside abort_i is still accepted (ready depends on state only); abort
  // then takes priority over the normal LOAD->DRAIN progression.
  always_comb begin
    accept      = (state_q == LOAD) && data_valid_i;
    last_accept = accept && (count_q == (len_q - ONE));
    start_ok    = (len_i != '0) && (len_i <= MAX_LEN);
    start_load  = 1'b0;
    state_d     = state_q;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start_i) begin
          start_load = start_ok;
          state_d    = start_ok ? LOAD : ERR;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = ERR;
        end else if (last_accept) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = abort_i ? ERR : RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_ready_o = (state_q == LOAD);

  // State, counters and all registered outputs. Status outputs are derived
  // from the next state so they line up with the state they describe; the
  // write port lags the accepting cycle by exactly one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      count_q         <= '0;
      checksum_o      <= '0;
      wr_en_imem_o    <= 1'b0;
      addr_imem_o     <= BASE_ADDR;
      wr_instr_imem_o <= '0;
      cpu_reset_o     <= 1'b1;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_imem_o <= accept;
      if (start_load) begin
        len_q      <= len_i;
        count_q    <= '0;
        checksum_o <= '0;
      end else if (accept) begin
        addr_imem_o     <= BASE_ADDR + (WORD_BYTES * 32'(count_q));
        wr_instr_imem_o <= data_i;
        count_q         <= count_q + ONE;
        checksum_o      <= checksum_o + data_i;
      end
      cpu_reset_o <= (state_d != RUN);
      busy_o      <= (state_d == LOAD) || (state_d == DRAIN);
      done_o      <= (state_d == RUN);
      err_o       <= (state_d == ERR);
    end
  end

endmodule
